// File: rtl/mod_seq_ctrl.sv
// mod_seq_ctrl: square-wave modulation sequencer with period counting and an optional
// step-sync watchdog. Define MOD_SEQ_WATCHDOG_EN to build the watchdog and FAULT path;
// without it i_wd_limit and i_step_sync are ignored and o_wd_fault stays 0.
module mod_seq_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_half_period,
    input  logic             i_step_sync,
    input  logic [7:0]       i_wd_limit,
    output logic             o_status,
    output logic             o_trig,
    output logic             o_running,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic             o_wd_fault,
    output logic [2:0]       o_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HIGH  = 3'd1,
        ST_LOW   = 3'd2,
        ST_FAULT = 3'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] half_cnt;     // cycles remaining in the current half after this one
    logic [CNT_W-1:0] half_load_c;
    logic             low_exit_c;
    logic             wd_hit_c;

    // Half length latched at half entry; values below 2 are stretched to 2
    assign half_load_c = ((i_half_period < CNT_W'(2)) ? CNT_W'(2) : i_half_period) - CNT_W'(1);
    assign low_exit_c  = (state == ST_LOW) && (half_cnt == '0);
    assign o_state     = state;

`ifdef MOD_SEQ_WATCHDOG_EN
    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W-1:0] wd_next_c;

    assign wd_next_c = wd_cnt + CNT_W'(1);
    // A step sync on the exiting cycle clears the count and suppresses the fault
    assign wd_hit_c  = low_exit_c && !i_step_sync && (i_wd_limit != 8'd0)
                       && (wd_next_c == CNT_W'(i_wd_limit));

    // Watchdog count: periods since the last step sync while running
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wd_cnt <= '0;
        end else if ((state == ST_IDLE) && i_en) begin
            wd_cnt <= '0;
        end else if (((state == ST_HIGH) || (state == ST_LOW)) && i_step_sync) begin
            wd_cnt <= '0;
        end else if (low_exit_c) begin
            wd_cnt <= wd_next_c;
        end
    end

    // Fault flag: set on the tripping LOW exit, released when FAULT drops to IDLE
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_wd_fault <= 1'b0;
        end else if (wd_hit_c) begin
            o_wd_fault <= 1'b1;
        end else if ((state == ST_FAULT) && !i_en) begin
            o_wd_fault <= 1'b0;
        end
    end
`else
    logic unused_wd;

    assign unused_wd  = ^{i_step_sync, i_wd_limit};
    assign wd_hit_c   = 1'b0;
    assign o_wd_fault = 1'b0;
`endif

    // Sequencer FSM with registered level, trigger, running and period count
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            half_cnt    <= '0;
            o_status    <= 1'b0;
            o_trig      <= 1'b0;
            o_running   <= 1'b0;
            o_cycle_cnt <= '0;
        end else begin
            o_trig <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_en) begin
                        state       <= ST_HIGH;
                        half_cnt    <= half_load_c;
                        o_status    <= 1'b1;
                        o_trig      <= 1'b1;
                        o_running   <= 1'b1;
                        o_cycle_cnt <= '0;
                    end
                end
                ST_HIGH: begin
                    if (half_cnt == '0) begin
                        state    <= ST_LOW;
                        half_cnt <= half_load_c;
                        o_status <= 1'b0;
                        o_trig   <= 1'b1;
                    end else begin
                        half_cnt <= half_cnt - CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    if (half_cnt == '0) begin
                        if (o_cycle_cnt != '1) begin
                            o_cycle_cnt <= o_cycle_cnt + CNT_W'(1);
                        end
                        if (wd_hit_c) begin
                            state     <= ST_FAULT;
                            o_status  <= 1'b0;
                            o_running <= 1'b0;
                        end else if (i_en) begin
                            state    <= ST_HIGH;
                            half_cnt <= half_load_c;
                            o_status <= 1'b1;
                            o_trig   <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            o_status  <= 1'b0;
                            o_running <= 1'b0;
                        end
                    end else begin
                        half_cnt <= half_cnt - CNT_W'(1);
                    end
                end
                ST_FAULT: begin
                    if (!i_en) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    o_status  <= 1'b0;
                    o_running <= 1'b0;
                end
            endcase
        end
    end

endmodule
